// File: rtl/jtag_scan_master_if.sv
// jtag_scan_master_if: command/response bundle between a scan host and jtag_scan_master.
interface jtag_scan_master_if #(
    parameter int MAX_LEN = 38
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_ir;
    logic [5:0]         cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               tap_reset_req;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               rsp_err;
    logic               busy;
    modport master (
        output cmd_valid, cmd_ir, cmd_len, cmd_data, tap_reset_req,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
    );
    modport slave (
        input  cmd_valid, cmd_ir, cmd_len, cmd_data, tap_reset_req,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: drives a JTAG TAP through TLR init and IR/DR scans,
// with TCK generated from clk by a programmable half-period divider.
module jtag_scan_master #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 38
) (
    input  logic              clk,
    input  logic              reset_n,
    jtag_scan_master_if.slave bus,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);
    typedef enum logic [2:0] {INIT, IDLE, WALK_IN, SHIFT, WALK_OUT, RESP} state_t;
    localparam logic [8:0] C_RISE = 9'(CLK_DIV - 1);
    localparam logic [8:0] C_END  = 9'(2 * CLK_DIV - 1);
    state_t             r_state;
    logic [5:0]         r_step;
    logic [8:0]         r_cnt;
    logic               r_tck, r_tms, r_tdi;
    logic               r_ready, r_busy, r_rsp_valid, r_rsp_err;
    logic               r_ir;
    logic [5:0]         r_len;
    logic [MAX_LEN-1:0] r_data, r_cap, r_rsp_data;
    logic               w_last, w_ntms, w_ntdi, w_len_bad;
    state_t             w_nstate;
    logic [5:0]         w_nstep;
    assign tck           = r_tck;
    assign tms           = r_tms;
    assign tdi           = r_tdi;
    assign bus.cmd_ready = r_ready & ~bus.tap_reset_req;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_busy;
    assign w_len_bad     = bus.cmd_len == 6'd0 || bus.cmd_len > 6'(MAX_LEN);
    // Next TAP step and the TMS/TDI it needs, loaded at the start of its low phase
    always_comb begin
        w_last   = (r_state == INIT && r_step == 6'd5) ||
                   (r_state == WALK_IN && r_step == (r_ir ? 6'd3 : 6'd2)) ||
                   (r_state == SHIFT && r_step == r_len - 6'd1) ||
                   (r_state == WALK_OUT && r_step == 6'd1);
        w_nstate = !w_last ? r_state :
                   r_state == INIT ? IDLE :
                   r_state == WALK_IN ? SHIFT :
                   r_state == SHIFT ? WALK_OUT : RESP;
        w_nstep  = w_last ? 6'd0 : r_step + 6'd1;
        w_ntms   = w_nstate == INIT ? (w_nstep != 6'd5) :
                   w_nstate == WALK_IN ? (w_nstep == 6'd0 || (r_ir && w_nstep == 6'd1)) :
                   w_nstate == SHIFT ? (w_nstep == r_len - 6'd1) :
                   w_nstate == WALK_OUT ? (w_nstep == 6'd0) : 1'b0;
        w_ntdi   = w_nstate == SHIFT && r_data[w_nstep];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= INIT;
            r_step      <= '0;
            r_cnt       <= '0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_ir        <= 1'b0;
            r_len       <= '0;
            r_data      <= '0;
            r_cap       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.tap_reset_req) begin
                        r_state <= INIT;
                        r_step  <= '0;
                        r_cnt   <= '0;
                        r_tms   <= 1'b1;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (bus.cmd_valid) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (w_len_bad) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                        end else begin
                            r_state <= WALK_IN;
                            r_step  <= '0;
                            r_cnt   <= '0;
                            r_tms   <= 1'b1;
                            r_ir    <= bus.cmd_ir;
                            r_len   <= bus.cmd_len;
                            r_data  <= bus.cmd_data;
                            r_cap   <= '0;
                        end
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_ready     <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    if (r_cnt == C_RISE) begin
                        r_tck <= 1'b1;
                        r_cnt <= r_cnt + 9'd1;
                        if (r_state == SHIFT) r_cap[r_step] <= tdo;
                    end else if (r_cnt == C_END) begin
                        r_tck   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= w_nstate;
                        r_step  <= w_nstep;
                        r_tms   <= w_ntms;
                        r_tdi   <= w_ntdi;
                        if (w_nstate == IDLE) begin
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                        if (w_nstate == RESP) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= r_cap;
                        end
                    end else begin
                        r_cnt <= r_cnt + 9'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: directed scans checked against per-step and per-response scoreboards.
module tb_jtag_scan_master;
    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 38;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tck, tms, tdi, tdo;
    int   tdo_mode = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_rise = 0;
    int   n_rsp = 0;
    logic prev_tck = 1'b0;
    logic [1:0]       q_step[$];
    logic [MAX_LEN:0] q_rsp[$];
    jtag_scan_master_if #(.MAX_LEN(MAX_LEN)) bus();
    jtag_scan_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );
    always #5 clk = ~clk;
    assign tdo = (tdo_mode == 2) ? tdi : (tdo_mode == 1);
    task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask
    always @(negedge clk) begin
        if (tck && !prev_tck) begin
            n_rise++;
            check("step_expected", 64'(q_step.size() > 0), 64'd1);
            if (q_step.size() > 0) check("tms_tdi", {62'd0, tms, tdi}, {62'd0, q_step.pop_front()});
        end
        prev_tck = tck;
        if (bus.rsp_valid) begin
            n_rsp++;
            check("rsp_expected", 64'(q_rsp.size() > 0), 64'd1);
            if (q_rsp.size() > 0) check("rsp", 64'({bus.rsp_err, bus.rsp_data}), 64'(q_rsp.pop_front()));
        end
    end
    task automatic push_init();
        for (int i = 0; i < 6; i++) q_step.push_back({i != 5, 1'b0});
    endtask
    task automatic push_scan(logic ir, int len, logic [MAX_LEN-1:0] d);
        q_step.push_back(2'b10);
        if (ir) q_step.push_back(2'b10);
        q_step.push_back(2'b00);
        q_step.push_back(2'b00);
        for (int i = 0; i < len; i++) q_step.push_back({i == len - 1, d[i]});
        q_step.push_back(2'b10);
        q_step.push_back(2'b00);
    endtask
    task automatic drive_cmd(logic ir, logic [5:0] len, logic [MAX_LEN-1:0] d);
        int t = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_ir    = ir;
        bus.cmd_len   = len;
        bus.cmd_data  = d;
        #1;
        while (!bus.cmd_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("cmd_accept", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask
    task automatic wait_rsp(int n0);
        int t = 0;
        while (n_rsp == n0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("rsp_arrived", 64'(n_rsp != n0), 64'd1);
    endtask
    task automatic wait_ready();
        int t = 0;
        while (!bus.cmd_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("ready_timeout", 64'(bus.cmd_ready), 64'd1);
    endtask
    task automatic scan(logic ir, logic [5:0] len, logic [MAX_LEN-1:0] d, int mode);
        logic [MAX_LEN-1:0] mask, e;
        int r0, n0;
        mask = '0;
        for (int i = 0; i < int'(len); i++) mask[i] = 1'b1;
        e = (mode == 0) ? '0 : (mode == 1) ? mask : (d & mask);
        tdo_mode = mode;
        q_rsp.push_back({1'b0, e});
        push_scan(ir, int'(len), d);
        r0 = n_rise;
        n0 = n_rsp;
        drive_cmd(ir, len, d);
        check("busy_scan", 64'(bus.busy), 64'd1);
        wait_rsp(n0);
        check("rise_count", 64'(n_rise - r0), 64'(int'(len) + (ir ? 6 : 5)));
        @(negedge clk);
        check("rsp_pulse_end", 64'(bus.rsp_valid), 64'd0);
        check("busy_idle", 64'(bus.busy), 64'd0);
        check("rsp_hold", 64'(bus.rsp_data), 64'(e));
    endtask
    task automatic illegal(logic [5:0] len);
        int r0;
        q_rsp.push_back({1'b1, {MAX_LEN{1'b0}}});
        r0 = n_rise;
        drive_cmd(1'b0, len, {MAX_LEN{1'b1}});
        check("illegal_valid", 64'(bus.rsp_valid), 64'd1);
        check("illegal_err", 64'(bus.rsp_err), 64'd1);
        @(negedge clk);
        check("illegal_valid_end", 64'(bus.rsp_valid), 64'd0);
        check("illegal_err_end", 64'(bus.rsp_err), 64'd0);
        repeat (4) @(negedge clk);
        check("illegal_no_tck", 64'(n_rise - r0), 64'd0);
    endtask
    initial begin
        int r0, n0, t;
        bus.cmd_valid = 1'b0;
        bus.cmd_ir = 1'b0;
        bus.cmd_len = '0;
        bus.cmd_data = '0;
        bus.tap_reset_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tck", 64'(tck), 64'd0);
        check("rst_tms", 64'(tms), 64'd1);
        check("rst_tdi", 64'(tdi), 64'd0);
        check("rst_ready", 64'(bus.cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd1);
        push_init();
        r0 = n_rise;
        reset_n = 1'b1;
        repeat (23) @(negedge clk);
        check("init_ready_23", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk);
        check("init_ready_24", 64'(bus.cmd_ready), 64'd1);
        check("init_busy", 64'(bus.busy), 64'd0);
        check("init_rises", 64'(n_rise - r0), 64'd6);
        scan(1'b1, 6'd2, 38'b10, 0);
        scan(1'b0, 6'd38, 38'h2A_AAAA_AAAA, 2);
        scan(1'b0, 6'd5, 38'h15, 1);
        scan(1'b1, 6'd7, 38'h5B, 2);
        scan(1'b0, 6'd1, 38'h1, 2);
        illegal(6'd0);
        illegal(6'd39);
        // Reset request together with a command: reset wins, no response
        n0 = n_rsp;
        r0 = n_rise;
        push_init();
        @(negedge clk);
        bus.tap_reset_req = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_len = 6'd3;
        #1;
        check("ready_low_on_req", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk);
        bus.tap_reset_req = 1'b0;
        bus.cmd_valid = 1'b0;
        check("req_busy", 64'(bus.busy), 64'd1);
        wait_ready();
        check("req_rises", 64'(n_rise - r0), 64'd6);
        check("req_no_rsp", 64'(n_rsp - n0), 64'd0);
        // Reset request during a scan is ignored
        fork
            scan(1'b0, 6'd4, 38'h9, 2);
            begin
                repeat (10) @(negedge clk);
                bus.tap_reset_req = 1'b1;
                @(negedge clk);
                bus.tap_reset_req = 1'b0;
            end
        join
        // reset_n asserted at tck rise 10 of a DR scan aborts it
        tdo_mode = 2;
        push_scan(1'b0, 20, 38'h3_1234);
        r0 = n_rise;
        n0 = n_rsp;
        drive_cmd(1'b0, 6'd20, 38'h3_1234);
        t = 0;
        while (n_rise < r0 + 10 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("abort_reached", 64'(n_rise - r0), 64'd10);
        reset_n = 1'b0;
        #1;
        check("abort_tck", 64'(tck), 64'd0);
        check("abort_tms", 64'(tms), 64'd1);
        check("abort_tdi", 64'(tdi), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd1);
        check("abort_ready", 64'(bus.cmd_ready), 64'd0);
        check("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("abort_rsp_data", 64'(bus.rsp_data), 64'd0);
        q_step.delete();
        repeat (3) @(negedge clk);
        push_init();
        r0 = n_rise;
        reset_n = 1'b1;
        wait_ready();
        check("abort_init_rises", 64'(n_rise - r0), 64'd6);
        check("abort_no_rsp", 64'(n_rsp - n0), 64'd0);
        scan(1'b0, 6'd3, 38'h6, 1);
        check("steps_drained", 64'(q_step.size()), 64'd0);
        check("rsps_drained", 64'(q_rsp.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtag_scan_master.md
JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning the TCK half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter MAX_LEN, default 38, meaning the maximum scan length in bits.
REQ-003 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-007 cmd_ir  input  1  1=IR scan, 0=DR scan.
REQ-008 cmd_len  input  6  number of bits to shift.
REQ-009 cmd_data  input  MAX_LEN  TDI bits, LSB shifted first.
REQ-010 tap_reset_req  input  1  single-cycle pulse requesting a Test-Logic-Reset (TLR) walk.
REQ-011 rsp_valid  output  1  one-cycle pulse; response is valid.
REQ-012 rsp_data  output  MAX_LEN  captured TDO bits.
REQ-013 rsp_err  output  1  qualifies rsp_valid; 1 means the command was illegal.
REQ-014 busy  output  1  high whenever a TAP walk or scan is in progress.
REQ-015 tck, tms, tdi  output  1 each  JTAG drive to the target TAP.
REQ-016 tdo  input  1  JTAG data from the target TAP.

Function
REQ-017 One TAP step SHALL be one TCK period of 2*CLK_DIV clk cycles, consisting of CLK_DIV cycles low followed by CLK_DIV cycles high.
REQ-018 tck SHALL idle low.
REQ-019 tms and tdi SHALL change only at the start of a low phase.
REQ-020 tdo SHALL be sampled in the clk cycle in which tck rises.
REQ-021 The FSM SHALL have the states INIT, IDLE, WALK_IN, SHIFT, WALK_OUT, RESP.
REQ-022 INIT SHALL drive 6 steps with TMS=1,1,1,1,1,0, leaving the TAP in Run-Test/Idle, then go to IDLE.
REQ-023 cmd_ready SHALL be high only in IDLE and SHALL be low whenever tap_reset_req is high.
REQ-024 An accepted command with cmd_len in 1..MAX_LEN SHALL latch cmd_ir, cmd_len and cmd_data.
REQ-025 WALK_IN SHALL drive TMS=1,0,0 for a DR scan and TMS=1,1,0,0 for an IR scan.
REQ-026 SHIFT SHALL drive cmd_len steps with tdi = cmd_data[i] at step i, TMS=0 except TMS=1 on the last step.
REQ-027 During SHIFT, the tdo sample taken at step i SHALL be stored to rsp_data[i].
REQ-028 rsp_data bits at index cmd_len and above SHALL be 0.
REQ-029 WALK_OUT SHALL drive TMS=1 (Update) then TMS=0 (Idle).
REQ-030 Total TCK rising edges SHALL be cmd_len+5 for a DR scan and cmd_len+6 for an IR scan.
REQ-031 RESP SHALL pulse rsp_valid=1, rsp_err=0 for exactly one clk cycle after the last tck falling edge, then return to IDLE.
REQ-032 rsp_data SHALL hold its value until the next response.
REQ-033 An accepted command with cmd_len=0 or cmd_len>MAX_LEN SHALL produce no tck edges and SHALL pulse rsp_valid=1, rsp_err=1, rsp_data=0 on the next clk cycle.
REQ-034 A tap_reset_req received in IDLE SHALL re-enter INIT and SHALL produce no response.
REQ-035 If tap_reset_req and cmd_valid are high in the same cycle, the reset SHALL win and the command SHALL not be accepted.
REQ-036 A tap_reset_req received while busy SHALL be ignored.
REQ-037 busy SHALL be high in every state other than IDLE.
REQ-038 tdi SHALL be 0 outside SHIFT.

Reset
REQ-039 While reset_n is low, the block SHALL hold tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=1.
REQ-040 Assertion of reset_n mid-scan SHALL abort the scan immediately, with no response.
REQ-041 After reset_n deasserts, the FSM SHALL start in INIT.

Verification (CLK_DIV=2)
REQ-042 Release reset -> 6 tck rises with tms=1,1,1,1,1,0; cmd_ready goes high 24 clk cycles after release.
REQ-043 IR scan, len=2, data=2'b10, tdo=0 -> 8 tck rises; tms=1,1,0,0,0,1,1,0; tdi on the shift steps =0,1; rsp_data=0, rsp_err=0.
REQ-044 DR scan, len=38, data=38'h2A_AAAA_AAAA, tdo wired to tdi -> 43 tck rises; rsp_data=38'h2A_AAAA_AAAA.
REQ-045 DR scan, len=5, tdo held 1 -> rsp_data=38'h1F.
REQ-046 cmd_len=0 and separately cmd_len=39 -> no tck edge; rsp_valid and rsp_err each pulse one cycle after acceptance.
REQ-047 reset_n low at tck rise 10 of a DR scan -> outputs take reset values within the same cycle, no rsp_valid; after release, INIT is repeated.
